// File: rtl/find_my_best_if.sv
// find_my_best_if: memory-port and control bundle for find_my_best.
// The master modport is the scanner (drives address/write side), the slave
// modport is the memory/controller side (drives read data and control).
interface find_my_best_if;
  logic        en;
  logic        start;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        done;

  modport master (
    input  en, start, data_in,
    output address, wr_en, data_out, done
  );

  modport slave (
    output en, start, data_in,
    input  address, wr_en, data_out, done
  );
endinterface

// File: rtl/find_my_best.sv
// find_my_best: scans the neighbour table and writes the ID and Q-value of
// the neighbour with the highest Q to two fixed result words.
// Optional feature macro: FMB_HOPS_TIEBREAK_EN -- adds a hop-count read per
// entry; equal Q-values are then resolved in favour of the smaller hop count.
// Without it, equal Q-values keep the earliest (lowest index) entry.
module find_my_best #(
  parameter int unsigned MAX_NEIGHBORS = 16,
  parameter logic [10:0] NCOUNT_ADDR   = 11'h274,
  parameter logic [10:0] ID_BASE       = 11'h300,
  parameter logic [10:0] Q_BASE        = 11'h340,
  parameter logic [10:0] HOP_BASE      = 11'h360,
  parameter logic [10:0] RES_ID_ADDR   = 11'h380,
  parameter logic [10:0] RES_Q_ADDR    = 11'h382
) (
  input  logic           clock,
  input  logic           nrst,
  find_my_best_if.master bus
);

  localparam logic [4:0]  MAX_N5  = 5'(MAX_NEIGHBORS);
  localparam logic [15:0] MAX_N16 = 16'(MAX_NEIGHBORS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_NCOUNT,
    S_RD_ID,
    S_RD_Q,
`ifdef FMB_HOPS_TIEBREAK_EN
    S_RD_HOP,
`endif
    S_WR_ID,
    S_WR_Q,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [10:0] addr_q;
  logic        wr_en_q;
  logic [15:0] data_out_q;
  logic        done_q;
  logic [15:0] best_id_q;
  logic [15:0] best_q_q;
  logic [4:0]  index_q;
  logic [4:0]  count_q;
  logic [15:0] cur_id_q;
`ifdef FMB_HOPS_TIEBREAK_EN
  logic [15:0] cur_q_q;
  logic [15:0] best_hops_q;
`endif

  logic [4:0]  count_d;
  logic [10:0] idx_off_d;
  logic [10:0] nxt_off_d;
  logic        last_d;
  logic        take_d;
  logic [15:0] cand_q_d;

  // Clamped count, table offsets and the replace-the-best decision.
  always_comb begin
    count_d   = (bus.data_in > MAX_N16) ? MAX_N5 : bus.data_in[4:0];
    idx_off_d = {5'd0, index_q, 1'b0};
    nxt_off_d = {5'd0, index_q + 5'd1, 1'b0};
    last_d    = ((index_q + 5'd1) == count_q);
`ifdef FMB_HOPS_TIEBREAK_EN
    // Q was latched in S_RD_Q; data_in now carries the hop count.
    cand_q_d  = cur_q_q;
    take_d    = (index_q == 5'd0) || (cur_q_q > best_q_q) ||
                ((cur_q_q == best_q_q) && (bus.data_in < best_hops_q));
`else
    // Strict greater-than keeps the incumbent on a tie.
    cand_q_d  = bus.data_in;
    take_d    = (index_q == 5'd0) || (bus.data_in > best_q_q);
`endif
  end

  // Scan FSM with registered memory-port outputs.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      addr_q      <= 11'd0;
      wr_en_q     <= 1'b0;
      data_out_q  <= 16'd0;
      done_q      <= 1'b0;
      best_id_q   <= 16'hFFFF;
      best_q_q    <= 16'd0;
      index_q     <= 5'd0;
      count_q     <= 5'd0;
      cur_id_q    <= 16'd0;
`ifdef FMB_HOPS_TIEBREAK_EN
      cur_q_q     <= 16'd0;
      best_hops_q <= 16'hFFFF;
`endif
    end else if (!bus.en && (state_q != S_IDLE)) begin
      // Abort: a write already on the port stays done, nothing more follows.
      state_q <= S_IDLE;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          if (bus.en && bus.start) begin
            best_id_q   <= 16'hFFFF;
            best_q_q    <= 16'd0;
`ifdef FMB_HOPS_TIEBREAK_EN
            best_hops_q <= 16'hFFFF;
`endif
            index_q     <= 5'd0;
            addr_q      <= NCOUNT_ADDR;
            state_q     <= S_RD_NCOUNT;
          end
        end
        S_RD_NCOUNT: begin
          count_q <= count_d;
          if (count_d == 5'd0) begin
            state_q <= S_WR_ID;
          end else begin
            addr_q  <= ID_BASE;
            state_q <= S_RD_ID;
          end
        end
        S_RD_ID: begin
          cur_id_q <= bus.data_in;
          addr_q   <= Q_BASE + idx_off_d;
          state_q  <= S_RD_Q;
        end
`ifdef FMB_HOPS_TIEBREAK_EN
        S_RD_Q: begin
          cur_q_q <= bus.data_in;
          addr_q  <= HOP_BASE + idx_off_d;
          state_q <= S_RD_HOP;
        end
        S_RD_HOP: begin
`else
        S_RD_Q: begin
`endif
          // Compare-and-advance step, last read of each entry.
          if (take_d) begin
            best_id_q   <= cur_id_q;
            best_q_q    <= cand_q_d;
`ifdef FMB_HOPS_TIEBREAK_EN
            best_hops_q <= bus.data_in;
`endif
          end
          if (last_d) begin
            state_q <= S_WR_ID;
          end else begin
            index_q <= index_q + 5'd1;
            addr_q  <= ID_BASE + nxt_off_d;
            state_q <= S_RD_ID;
          end
        end
        S_WR_ID: begin
          addr_q     <= RES_ID_ADDR;
          data_out_q <= best_id_q;
          wr_en_q    <= 1'b1;
          state_q    <= S_WR_Q;
        end
        S_WR_Q: begin
          addr_q     <= RES_Q_ADDR;
          data_out_q <= best_q_q;
          wr_en_q    <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.address  = addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.data_out = data_out_q;
  assign bus.done     = done_q;

endmodule

// File: doc/find_my_best.md
# find_my_best

Scans the node's neighbour table after the cluster-head list has been fixed and selects the neighbour with the highest Q-value as the next-hop. It sits directly downstream of the cluster-head list fixer, is started by that block's completion, and shares the same 2048-byte data memory port (11-bit byte address, 16-bit word). The chosen neighbour ID and its Q-value are written back to fixed result words for the packet-forwarding stage.

## Interface
Parameters:
- MAX_NEIGHBORS, 16: table depth; neighbour count is clamped to this value.
- NCOUNT_ADDR, 11'h274: neighbour count word.
- ID_BASE, 11'h300: neighbour ID table; entry i is at ID_BASE + 2*i.
- Q_BASE, 11'h340: neighbour Q-value table; entry i is at Q_BASE + 2*i.
- HOP_BASE, 11'h360: neighbour hop-count table (used only with tie-break).
- RES_ID_ADDR, 11'h380: result word for the best ID.
- RES_Q_ADDR, 11'h382: result word for the best Q-value.

Ports:
- clock  in  1  rising-edge clock. One clock only.
- nrst  in  1  synchronous, active-low reset.
- en  in  1  block enable. Low aborts any operation.
- start  in  1  begin a scan; sampled in S_IDLE only.
- data_in  in  16  memory read data; valid in the cycle after `address` changes.
- address  out  11  memory byte address (registered).
- wr_en  out  1  memory write strobe (registered).
- data_out  out  16  memory write data (registered).
- done  out  1  single-cycle completion pulse.

## Operation
- Reset (nrst=0 at an edge): state S_IDLE; address=0, wr_en=0, data_out=0, done=0; bestID=16'hFFFF, bestQ=0, bestHops=16'hFFFF, index=0, count=0.
- S_IDLE: if en & start, then clear best registers, set index=0 and address=NCOUNT_ADDR, and go to S_RD_NCOUNT.
- S_RD_NCOUNT: count = min(data_in, MAX_NEIGHBORS). If count==0, go to S_WR_ID. Otherwise set address=ID_BASE and go to S_RD_ID.
- S_RD_ID: latch curID=data_in, set address=Q_BASE+2*index, and go to S_RD_Q.
- S_RD_Q: latch curQ. Compare as unsigned 16-bit. Replace the best if curQ > bestQ, or if this is the first entry (index 0). The first entry always seeds the best, even when its Q is 0.
  - Tie (curQ == bestQ) with the macro off: keep the incumbent, so the lowest index wins.
  - Then either advance to the next entry (index+1, address=ID_BASE+2*(index+1), S_RD_ID), or, after the last entry, go to S_WR_ID.
- S_WR_ID: address=RES_ID_ADDR, data_out=bestID, wr_en=1, then S_WR_Q.
- S_WR_Q: address=RES_Q_ADDR, data_out=bestQ, wr_en=1, then S_DONE.
- S_DONE: wr_en=0, done=1 for one cycle, then S_IDLE.
- done is 0 in every state other than S_DONE.
- en low at any edge outside S_IDLE:
  - go to S_IDLE with wr_en=0, done=0;
  - a result write already issued is not retracted, and no further writes are made.
- Index arithmetic is 5-bit. Address arithmetic wraps modulo 2^11.

## Timing
- The start accept edge is T. Scan reads happen at T+1 … T+2N+1, for N = clamped count.
- Writes are visible with wr_en=1 in the cycles after edges T+2N+2 (ID) and T+2N+3 (Q).
- done is high after edge T+2N+4. Total latency is 2N+4 cycles.
- N=0: writes after T+2 and T+3, done after T+4.
- With FMB_HOPS_TIEBREAK_EN the scan costs 3 cycles per entry, so done comes after T+3N+4.
- A start asserted while busy is ignored.
- A start in the same cycle as done's S_IDLE return is not accepted until the next cycle.

## Configuration
- FMB_HOPS_TIEBREAK_EN, when defined:
  - adds state S_RD_HOP after S_RD_Q, which reads HOP_BASE+2*index;
  - the comparison moves into S_RD_HOP;
  - on an equal Q, the entry with the smaller hop count wins; equal hops keep the lower index.
  - bestHops is tracked.
- FMB_HOPS_TIEBREAK_EN, when undefined:
  - no hop reads; ties are resolved by lowest index;
  - bestHops and S_RD_HOP do not exist.

## Test plan
- N=3, IDs {5,9,12}, Q {0x0010,0x0040,0x0020}, start at edge T -> writes 0x0009 @0x380 and 0x0040 @0x382; done after T+10.
- N=2, IDs {7,3}, Q {0x0030,0x0030}, hops {4,2} -> macro off: 0x0007 / 0x0030; macro on: 0x0003 / 0x0030 with done after T+10.
- N=0 -> writes 0xFFFF @0x380 and 0x0000 @0x382; done after T+4; no table reads.
- Count word 20, entry 17 holds the largest Q -> clamped to 16 entries; entry 17 is never read; the result is the best of entries 0-15.
- en dropped during S_RD_Q of entry 1 (of 3) -> S_IDLE next edge; wr_en never 1; done never 1; a following start performs a full clean scan.
- nrst low for one edge during S_WR_ID -> all outputs 0 next cycle; no S_WR_Q write; no done.
